// File: rtl/xge_mac_wb_ctrl_if.sv
// Wishbone register-port bundle between the controller (master) and the xge_mac (slave).
interface xge_mac_wb_ctrl_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_int_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_int_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_int_i
    );
endinterface

// File: rtl/xge_mac_wb_ctrl.sv
// Wishbone master that initialises the xge_mac register port, then services its
// interrupt and forwards single host register accesses onto the same bus.
module xge_mac_wb_ctrl #(
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [7:0]  ADR_CFG      = 8'h00,
    parameter logic [7:0]  ADR_INT_PEND = 8'h08,
    parameter logic [7:0]  ADR_INT_MASK = 8'h10
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start_i,
    input  logic [31:0]              cfg_ctrl_i,
    input  logic [31:0]              cfg_int_mask_i,
    input  logic                     host_req_i,
    input  logic                     host_we_i,
    input  logic [7:0]               host_adr_i,
    input  logic [31:0]              host_wdat_i,
    output logic                     host_ack_o,
    output logic [31:0]              host_rdat_o,
    output logic                     host_err_o,
    xge_mac_wb_ctrl_if.master        wb,
    output logic                     init_done_o,
    output logic                     init_err_o,
    output logic                     timeout_err_o,
    output logic [31:0]              int_pending_o,
    input  logic                     int_clr_i,
    output logic                     int_evt_o,
    output logic                     busy_o
);
    typedef enum logic [2:0] {IDLE, INIT_CFG, INIT_MASK, INIT_CHK, RUN, ISR, HOST} state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        cyc, cyc_nxt, we, we_nxt;
    logic [7:0]  adr, adr_nxt, tcnt, tcnt_nxt;
    logic [31:0] dat, dat_nxt;
    logic        host_ack_nxt, host_err_nxt, int_evt_nxt;
    logic [31:0] host_rdat_nxt, int_pending_nxt;
    logic        init_done_nxt, init_err_nxt, timeout_err_nxt;
    logic        done, expired, launch, l_we;
    logic [7:0]  l_adr;
    logic [31:0] l_dat;

    assign wb.wb_cyc_o = cyc;
    assign wb.wb_stb_o = cyc;
    assign wb.wb_we_o  = we;
    assign wb.wb_adr_o = adr;
    assign wb.wb_dat_o = dat;
    assign busy_o      = cyc;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            cyc           <= 1'b0;
            we            <= 1'b0;
            adr           <= '0;
            dat           <= '0;
            tcnt          <= '0;
            host_ack_o    <= 1'b0;
            host_err_o    <= 1'b0;
            host_rdat_o   <= '0;
            int_evt_o     <= 1'b0;
            int_pending_o <= '0;
            init_done_o   <= 1'b0;
            init_err_o    <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            cyc           <= cyc_nxt;
            we            <= we_nxt;
            adr           <= adr_nxt;
            dat           <= dat_nxt;
            tcnt          <= tcnt_nxt;
            host_ack_o    <= host_ack_nxt;
            host_err_o    <= host_err_nxt;
            host_rdat_o   <= host_rdat_nxt;
            int_evt_o     <= int_evt_nxt;
            int_pending_o <= int_pending_nxt;
            init_done_o   <= init_done_nxt;
            init_err_o    <= init_err_nxt;
            timeout_err_o <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cyc_nxt         = cyc;
        we_nxt          = we;
        adr_nxt         = adr;
        dat_nxt         = dat;
        tcnt_nxt        = tcnt;
        host_ack_nxt    = 1'b0;
        host_err_nxt    = 1'b0;
        host_rdat_nxt   = host_rdat_o;
        int_evt_nxt     = 1'b0;
        int_pending_nxt = int_clr_i ? 32'h0 : int_pending_o;
        init_done_nxt   = init_done_o;
        init_err_nxt    = init_err_o;
        timeout_err_nxt = timeout_err_o;
        launch          = 1'b0;
        l_we            = 1'b0;
        l_adr           = adr;
        l_dat           = '0;

        done    = cyc && wb.wb_ack_i;
        expired = cyc && !wb.wb_ack_i && (tcnt == TCNT_LAST);

        if (done || expired) begin
            cyc_nxt  = 1'b0;
            we_nxt   = 1'b0;
            tcnt_nxt = '0;
        end else if (cyc) begin
            tcnt_nxt = tcnt + 8'd1;
        end

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt     = INIT_CFG;
                    init_done_nxt = 1'b0;
                    init_err_nxt  = 1'b0;
                end
            end
            INIT_CFG, INIT_MASK, INIT_CHK: begin
                // Each init step launches on entry with cyc low, giving the idle clock.
                if (!cyc) begin
                    launch = 1'b1;
                    l_we   = (state != INIT_CHK);
                    l_adr  = (state == INIT_MASK) ? ADR_INT_MASK : ADR_CFG;
                    l_dat  = (state == INIT_MASK) ? cfg_int_mask_i :
                             (state == INIT_CFG)  ? cfg_ctrl_i : 32'h0;
                end else if (done) begin
                    if (state == INIT_CFG) begin
                        state_nxt = INIT_MASK;
                    end else if (state == INIT_MASK) begin
                        state_nxt = INIT_CHK;
                    end else begin
                        state_nxt = RUN;
                        if (wb.wb_dat_i == cfg_ctrl_i) init_done_nxt = 1'b1;
                        else                           init_err_nxt  = 1'b1;
                    end
                end else if (expired) begin
                    state_nxt       = IDLE;
                    init_err_nxt    = 1'b1;
                    timeout_err_nxt = 1'b1;
                end
            end
            RUN: begin
                if (wb.wb_int_i) begin
                    state_nxt = ISR;
                    launch    = 1'b1;
                    l_adr     = ADR_INT_PEND;
                end else if (host_req_i) begin
                    state_nxt = HOST;
                    launch    = 1'b1;
                    l_we      = host_we_i;
                    l_adr     = host_adr_i;
                    l_dat     = host_we_i ? host_wdat_i : 32'h0;
                end
            end
            ISR: begin
                if (done) begin
                    state_nxt       = RUN;
                    int_evt_nxt     = 1'b1;
                    int_pending_nxt = int_clr_i ? wb.wb_dat_i : (int_pending_o | wb.wb_dat_i);
                end else if (expired) begin
                    state_nxt       = RUN;
                    timeout_err_nxt = 1'b1;
                end
            end
            HOST: begin
                if (done) begin
                    state_nxt     = RUN;
                    host_ack_nxt  = 1'b1;
                    host_rdat_nxt = we ? 32'h0 : wb.wb_dat_i;
                end else if (expired) begin
                    state_nxt       = RUN;
                    host_ack_nxt    = 1'b1;
                    host_err_nxt    = 1'b1;
                    host_rdat_nxt   = 32'h0;
                    timeout_err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (launch) begin
            cyc_nxt  = 1'b1;
            we_nxt   = l_we;
            adr_nxt  = l_adr;
            dat_nxt  = l_dat;
            tcnt_nxt = '0;
        end
    end
endmodule

// File: tb/tb_xge_mac_wb_ctrl.sv
// Directed bench for xge_mac_wb_ctrl: a small register-port slave model plus
// scenario tasks for init, readback error, timeout, ISR/host arbitration and reset.
module tb_xge_mac_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_ctrl = '0;
    logic [31:0] cfg_mask = '0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_adr = '0;
    logic [31:0] host_wdat = '0;
    logic        host_ack, host_err;
    logic [31:0] host_rdat;
    logic        init_done, init_err, timeout_err, int_evt, busy;
    logic [31:0] int_pending;
    logic        int_clr = 1'b0;

    xge_mac_wb_ctrl_if wb ();

    xge_mac_wb_ctrl #(.TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .cfg_ctrl_i(cfg_ctrl), .cfg_int_mask_i(cfg_mask),
        .host_req_i(host_req), .host_we_i(host_we), .host_adr_i(host_adr),
        .host_wdat_i(host_wdat), .host_ack_o(host_ack), .host_rdat_o(host_rdat),
        .host_err_o(host_err), .wb(wb), .init_done_o(init_done),
        .init_err_o(init_err), .timeout_err_o(timeout_err),
        .int_pending_o(int_pending), .int_clr_i(int_clr), .int_evt_o(int_evt),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model: acks after wait_n wait states, clear-on-read pending value supplied by the bench.
    logic        ack_en = 1'b1;
    int          wait_n = 1;
    logic        rb_zero = 1'b0;
    logic [31:0] pend_val = '0;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdat = '0;
    int          wcnt = 0;
    logic [31:0] mem_cfg = '0;
    logic [31:0] mem_mask = '0;
    logic [7:0]  log_adr [0:63];
    logic        log_we  [0:63];
    int          log_n = 0;

    assign wb.wb_ack_i = s_ack;
    assign wb.wb_dat_i = s_rdat;

    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
            wcnt  <= 0;
        end else if (s_ack) begin
            s_ack <= 1'b0;
        end else if (wb.wb_cyc_o && wb.wb_stb_o && ack_en) begin
            if (wcnt == wait_n) begin
                s_ack <= 1'b1;
                wcnt  <= 0;
                if (log_n < 64) begin
                    log_adr[log_n] <= wb.wb_adr_o;
                    log_we[log_n]  <= wb.wb_we_o;
                    log_n          <= log_n + 1;
                end
                if (wb.wb_we_o) begin
                    if (wb.wb_adr_o == 8'h00) mem_cfg <= wb.wb_dat_o;
                    else if (wb.wb_adr_o == 8'h10) mem_mask <= wb.wb_dat_o;
                end else begin
                    case (wb.wb_adr_o)
                        8'h00:   s_rdat <= rb_zero ? 32'h0 : mem_cfg;
                        8'h08:   s_rdat <= pend_val;
                        8'h10:   s_rdat <= mem_mask;
                        default: s_rdat <= {24'hC0FFEE, wb.wb_adr_o};
                    endcase
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_for(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (sel)
                0:       ok = init_done || init_err;
                1:       ok = init_err;
                2:       ok = host_ack;
                3:       ok = int_evt;
                default: ok = wb.wb_stb_o;
            endcase
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] agg;
        wb.wb_int_i = 1'b0;
        do_reset();
        agg = {host_ack, host_err, init_done, init_err, timeout_err, int_evt, busy,
               wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, 22'h0};
        checks++; if (agg !== 32'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", agg); end
        checks++; if (int_pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", int_pending); end
        checks++; if (host_rdat !== 32'h0) begin errors++; $display("FAIL reset_rdat: got %h expected 0", host_rdat); end
    endtask

    task automatic test_init_ok();
        bit ok;
        int base;
        base = log_n;
        cfg_ctrl = 32'h1; cfg_mask = 32'hFF; wait_n = 1; ack_en = 1'b1; rb_zero = 1'b0;
        pulse_start();
        wait_for(0, 200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_ok_wait: got %b expected 1", ok); end
        checks++; if ({init_done, init_err} !== 2'b10) begin errors++; $display("FAIL init_ok_flags: got %b expected 10", {init_done, init_err}); end
        checks++; if (log_n - base !== 3) begin errors++; $display("FAIL init_ok_ncyc: got %0d expected 3", log_n - base); end
        checks++; if ({log_adr[base], log_we[base], log_adr[base+1], log_we[base+1], log_adr[base+2], log_we[base+2]} !== {8'h00, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0})
            begin errors++; $display("FAIL init_ok_seq: got %h/%b %h/%b %h/%b expected 00/1 10/1 00/0", log_adr[base], log_we[base], log_adr[base+1], log_we[base+1], log_adr[base+2], log_we[base+2]); end
        checks++; if ({mem_cfg, mem_mask} !== {32'h1, 32'hFF}) begin errors++; $display("FAIL init_ok_regs: got %h %h expected 1 ff", mem_cfg, mem_mask); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL init_ok_tmo: got %b expected 0", timeout_err); end
    endtask

    task automatic host_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                               input int budget, output bit ok, output logic [31:0] rd, output logic er);
        @(negedge clk);
        host_req = 1'b1; host_we = w; host_adr = a; host_wdat = d;
        wait_for(2, budget, ok);
        rd = host_rdat; er = host_err;
        host_req = 1'b0;
    endtask

    task automatic test_readback_err();
        bit ok;
        logic [31:0] rd;
        logic er;
        do_reset();
        rb_zero = 1'b1;
        pulse_start();
        wait_for(0, 200, ok);
        rb_zero = 1'b0;
        checks++; if ({ok, init_done, init_err} !== 3'b101) begin errors++; $display("FAIL rb_err_flags: got %b expected 101", {ok, init_done, init_err}); end
        host_access(1'b0, 8'h0C, 32'h0, 100, ok, rd, er);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rb_err_host_ack: got %b expected 1", ok); end
        checks++; if ({rd, er} !== {32'hC0FFEE0C, 1'b0}) begin errors++; $display("FAIL rb_err_host_rdat: got %h/%b expected c0ffee0c/0", rd, er); end
    endtask

    task automatic test_init_timeout();
        bit ok;
        int stb_cnt;
        do_reset();
        ack_en = 1'b0;
        pulse_start();
        stb_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wb.wb_stb_o) stb_cnt++;
            if (init_err) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_wait: got %b expected 1", ok); end
        checks++; if (stb_cnt !== 16) begin errors++; $display("FAIL tmo_stb_cycles: got %0d expected 16", stb_cnt); end
        checks++; if ({timeout_err, init_err, init_done, busy} !== 4'b1100) begin errors++; $display("FAIL tmo_flags: got %b expected 1100", {timeout_err, init_err, init_done, busy}); end
        ack_en = 1'b1;
        pulse_start();
        checks++; if (init_err !== 1'b0) begin errors++; $display("FAIL tmo_retry_clear: got %b expected 0", init_err); end
        wait_for(0, 200, ok);
        checks++; if ({ok, init_done, init_err, timeout_err} !== 4'b1101) begin errors++; $display("FAIL tmo_retry_done: got %b expected 1101", {ok, init_done, init_err, timeout_err}); end
    endtask

    task automatic test_isr_host_arb();
        bit ok;
        int base, evt_cnt;
        logic [31:0] pend_at_evt, rd;
        base = log_n; evt_cnt = 0; pend_at_evt = '0; rd = '0; ok = 1'b0;
        @(negedge clk);
        pend_val = 32'h5; wb.wb_int_i = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_adr = 8'h0C;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int_evt) begin evt_cnt++; pend_at_evt = int_pending; wb.wb_int_i = 1'b0; end
            if (host_ack) begin ok = 1'b1; rd = host_rdat; break; end
        end
        host_req = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL arb_host_ack: got %b expected 1", ok); end
        checks++; if ({evt_cnt, pend_at_evt} !== {32'd1, 32'h5}) begin errors++; $display("FAIL arb_isr: got evt=%0d pend=%h expected 1/5", evt_cnt, pend_at_evt); end
        checks++; if ({log_adr[base], log_adr[base+1]} !== {8'h08, 8'h0C}) begin errors++; $display("FAIL arb_order: got %h,%h expected 08,0c", log_adr[base], log_adr[base+1]); end
        checks++; if (rd !== 32'hC0FFEE0C) begin errors++; $display("FAIL arb_rdat: got %h expected c0ffee0c", rd); end
        @(negedge clk);
        checks++; if ({int_evt, host_ack} !== 2'b00) begin errors++; $display("FAIL arb_pulses: got %b expected 00", {int_evt, host_ack}); end
    endtask

    task automatic run_isr(input logic [31:0] val, input logic clr_on_capture, output bit ok);
        @(negedge clk);
        pend_val = val; wb.wb_int_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            int_clr = clr_on_capture && wb.wb_ack_i && (wb.wb_adr_o == 8'h08);
            if (int_evt) begin ok = 1'b1; wb.wb_int_i = 1'b0; break; end
        end
        int_clr = 1'b0;
        wb.wb_int_i = 1'b0;
    endtask

    task automatic test_int_clr();
        bit ok;
        checks++; if (int_pending !== 32'h5) begin errors++; $display("FAIL clr_pre: got %h expected 5", int_pending); end
        run_isr(32'h2, 1'b1, ok);
        checks++; if ({ok, int_pending} !== {1'b1, 32'h2}) begin errors++; $display("FAIL clr_capture: got %b/%h expected 1/2", ok, int_pending); end
        run_isr(32'h8, 1'b0, ok);
        checks++; if ({ok, int_pending} !== {1'b1, 32'hA}) begin errors++; $display("FAIL isr_or: got %b/%h expected 1/a", ok, int_pending); end
        @(negedge clk); int_clr = 1'b1;
        @(negedge clk); int_clr = 1'b0;
        checks++; if (int_pending !== 32'h0) begin errors++; $display("FAIL clr_alone: got %h expected 0", int_pending); end
    endtask

    task automatic test_host_timeout();
        bit ok;
        logic [31:0] rd;
        logic er;
        ack_en = 1'b0;
        host_access(1'b0, 8'h0C, 32'h0, 100, ok, rd, er);
        ack_en = 1'b1;
        checks++; if ({ok, er, rd} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL host_tmo: got %b/%b/%h expected 1/1/0", ok, er, rd); end
        host_access(1'b1, 8'h20, 32'h1234, 100, ok, rd, er);
        checks++; if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL host_write: got %b/%b/%h expected 1/0/0", ok, er, rd); end
    endtask

    task automatic test_reset_mid_cycle();
        bit ok;
        int acks;
        logic [31:0] agg;
        ack_en = 1'b0;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_adr = 8'h20; host_wdat = 32'h1234;
        wait_for(4, 20, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_mid_stb: got %b expected 1", ok); end
        rst = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
        agg = {host_ack, host_err, init_done, init_err, timeout_err, int_evt, busy,
               wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, 22'h0};
        checks++; if (agg !== 32'h0) begin errors++; $display("FAIL rst_mid_flags: got %h expected 0", agg); end
        checks++; if ({wb.wb_adr_o, wb.wb_dat_o, int_pending, host_rdat} !== 104'h0) begin errors++; $display("FAIL rst_mid_data: got %h %h %h %h expected 0", wb.wb_adr_o, wb.wb_dat_o, int_pending, host_rdat); end
        rst = 1'b0;
        ack_en = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (host_ack || wb.wb_cyc_o) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d expected 0", acks); end
    endtask

    initial begin
        wb.wb_int_i = 1'b0;
        test_reset();
        test_init_ok();
        test_readback_err();
        test_init_timeout();
        test_isr_host_arb();
        test_int_clr();
        test_host_timeout();
        test_reset_mid_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
